seg7_capture: RTL

//  Display-side monitor: the decoder for the stopwatch's two bcd7seg encoders. Samples the
//  two 7-segment patterns (out1 = ones, out2 = tens), waits for them to settle, decodes them

---
 rtl/seg7_capture_if.sv | 31 +++
 rtl/seg7_capture.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/seg7_capture_if.sv
// Display-monitor bundle for seg7_capture: the two active-low segment patterns and the error clear
// go in; decoded value, pulses and counters come out.
interface seg7_capture_if #(
  parameter int CNT_W = 16
);
  logic [6:0]       seg_ones;
  logic [6:0]       seg_tens;
  logic             err_clr;
  logic [3:0]       bcd_ones;
  logic [3:0]       bcd_tens;
  logic [6:0]       bin_val;
  logic             val_valid;
  logic             new_pulse;
  logic             err_pulse;
  logic             err_sticky;
  logic [CNT_W-1:0] commit_cnt;
  logic             step_ok;
  logic             step_jump;

  modport master (
    output seg_ones, seg_tens, err_clr,
    input  bcd_ones, bcd_tens, bin_val, val_valid, new_pulse, err_pulse,
           err_sticky, commit_cnt, step_ok, step_jump
  );

  modport slave (
    input  seg_ones, seg_tens, err_clr,
    output bcd_ones, bcd_tens, bin_val, val_valid, new_pulse, err_pulse,
           err_sticky, commit_cnt, step_ok, step_jump
  );
endinterface

// File: rtl/seg7_capture.sv
// On-chip monitor that debounces two 7-segment patterns, decodes them to 00-99 and flags illegal
// patterns. Define SEG7_STEP_CHECK_EN to add the count-progression check (step_ok/step_jump).
module seg7_capture #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 16   // must match the interface CNT_W
) (
  input logic           clk,
  input logic           rst,
  seg7_capture_if.slave bus
);
  localparam int CW = $clog2(STABLE_CYCLES);

  typedef enum logic { ST_SETTLE, ST_HELD } state_t;

  state_t           r_state, w_state_nxt;
  logic [13:0]      r_samp;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic             w_commit;
  logic [13:0]      w_in;
  logic [4:0]       w_dec_o, w_dec_t;
  logic             w_legal;
  logic [6:0]       w_bin_nxt;

  logic [3:0]       r_bcd_o, r_bcd_t;
  logic [6:0]       r_bin;
  logic             r_valid, r_new, r_err, r_sticky;
  logic [CNT_W-1:0] r_ccnt;

  // {legal, digit}; blank and every non-table pattern decode as illegal
  function automatic logic [4:0] dec7(input logic [6:0] s);
    case (s)
      7'h40:   dec7 = 5'h10;
      7'h79:   dec7 = 5'h11;
      7'h24:   dec7 = 5'h12;
      7'h30:   dec7 = 5'h13;
      7'h19:   dec7 = 5'h14;
      7'h12:   dec7 = 5'h15;
      7'h02:   dec7 = 5'h16;
      7'h78:   dec7 = 5'h17;
      7'h00:   dec7 = 5'h18;
      7'h10:   dec7 = 5'h19;
      default: dec7 = 5'h00;
    endcase
  endfunction

  assign w_in      = {bus.seg_tens, bus.seg_ones};
  assign w_dec_o   = dec7(bus.seg_ones);
  assign w_dec_t   = dec7(bus.seg_tens);
  assign w_legal   = w_dec_o[4] & w_dec_t[4];
  assign w_bin_nxt = {w_dec_t[3:0], 3'b000} + {2'b00, w_dec_t[3:0], 1'b0} + {3'b000, w_dec_o[3:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_SETTLE;
      r_cnt   <= '0;
      r_samp  <= 14'h3FFF;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_samp  <= w_in;
    end
  end

  // Commit fires once per stable run; HELD blocks re-commits until the input moves.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_commit    = 1'b0;
    if (w_in != r_samp) begin
      w_cnt_nxt   = '0;
      w_state_nxt = ST_SETTLE;
    end else if (r_state == ST_SETTLE) begin
      if (r_cnt == CW'(STABLE_CYCLES - 1)) begin
        w_commit    = 1'b1;
        w_state_nxt = ST_HELD;
      end else begin
        w_cnt_nxt = r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bcd_o  <= '0;
      r_bcd_t  <= '0;
      r_bin    <= '0;
      r_valid  <= 1'b0;
      r_new    <= 1'b0;
      r_err    <= 1'b0;
      r_sticky <= 1'b0;
      r_ccnt   <= '0;
    end else begin
      r_new <= w_commit & w_legal;
      r_err <= w_commit & ~w_legal;
      if (w_commit && w_legal) begin
        r_bcd_o <= w_dec_o[3:0];
        r_bcd_t <= w_dec_t[3:0];
        r_bin   <= w_bin_nxt;
        r_valid <= 1'b1;
        if (r_ccnt != {CNT_W{1'b1}}) r_ccnt <= r_ccnt + 1'b1;
      end
      // a visible err_pulse also re-sets, so a clear landing on the pulse cycle loses
      r_sticky <= (w_commit & ~w_legal) | r_err | (r_sticky & ~bus.err_clr);
    end
  end

`ifdef SEG7_STEP_CHECK_EN
  logic       r_step_ok, r_step_jump;
  logic [6:0] w_old_p1;
  logic       w_step_hit;

  assign w_old_p1   = (r_bin == 7'd99) ? 7'd0 : r_bin + 7'd1;
  assign w_step_hit = (w_bin_nxt == w_old_p1) | (w_bin_nxt == r_bin);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_step_ok   <= 1'b0;
      r_step_jump <= 1'b0;
    end else begin
      r_step_ok   <= w_commit & w_legal & r_valid & w_step_hit;
      r_step_jump <= w_commit & w_legal & r_valid & ~w_step_hit;
    end
  end

  assign bus.step_ok   = r_step_ok;
  assign bus.step_jump = r_step_jump;
`else
  assign bus.step_ok   = 1'b0;
  assign bus.step_jump = 1'b0;
`endif

  assign bus.bcd_ones   = r_bcd_o;
  assign bus.bcd_tens   = r_bcd_t;
  assign bus.bin_val    = r_bin;
  assign bus.val_valid  = r_valid;
  assign bus.new_pulse  = r_new;
  assign bus.err_pulse  = r_err;
  assign bus.err_sticky = r_sticky;
  assign bus.commit_cnt = r_ccnt;
endmodule
